// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state encoding and GF(2^8) helpers
package aes_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  localparam logic [7:0] AES_POLY = 8'h1B;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction
  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction
endpackage

// File: rtl/aes_round_seq_if.sv
// aes_round_seq_if: start/abort handshake and datapath strobes of the round sequencer
interface aes_round_seq_if;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic [3:0] round;
  logic [1:0] phase;
  logic init_sel;
  logic step_en;
  logic mix_en;
  logic [31:0] rcon;
  modport master (output start, abort, input busy, done, round, phase, init_sel, step_en, mix_en, rcon);
  modport slave (input start, abort, output busy, done, round, phase, init_sel, step_en, mix_en, rcon);
endinterface

// File: rtl/aes_rcon_gen.sv
// aes_rcon_gen: round constant register, reloaded to 01 and advanced by xtime
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic        valid,
  output logic [31:0] rcon
);
  logic [7:0] rc;
  always_ff @(posedge clk) begin
    if (reset || load) rc <= 8'h01;
    else if (advance) rc <= xtime(rc);
  end
  assign rcon = valid ? {rc, 24'h0} : 32'h0;
endmodule

// File: rtl/aes_round_seq.sv
// aes_round_seq: counter-based AES-128/192/256 round sequencer with start/done handshake
module aes_round_seq
  import aes_pkg::*;
#(
  parameter int NK  = 4,
  parameter int CPR = 1
) (
  input  logic clk,
  input  logic reset,
  aes_round_seq_if.slave seq
);
  localparam logic [3:0] NR      = 4'(nr_of(NK));
  localparam logic [1:0] LAST_PH = 2'(CPR - 1);
  if (!(NK == 4 || NK == 6 || NK == 8) || CPR < 1 || CPR > 4) begin : g_bad_param
    $error("aes_round_seq: illegal NK=%0d CPR=%0d", NK, CPR);
  end
  seq_state_t state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [1:0] phase_q, phase_d;
  logic run, last_ph, last_rnd;
  assign run      = state_q == RUN;
  assign last_ph  = phase_q == LAST_PH;
  assign last_rnd = round_q == NR;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      phase_q <= 2'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      phase_q <= phase_d;
    end
  end
  // counters stay cleared outside RUN, so entering RUN always starts at round 0
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    phase_d = phase_q;
    unique case (state_q)
      IDLE: state_d = (seq.start && !seq.abort) ? RUN : IDLE;
      RUN: begin
        if (seq.abort) begin
          state_d = IDLE;
          round_d = 4'd0;
          phase_d = 2'd0;
        end else if (last_ph) begin
          phase_d = 2'd0;
          round_d = last_rnd ? 4'd0 : round_q + 4'd1;
          state_d = last_rnd ? DONE : RUN;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      DONE: state_d = seq.abort ? IDLE : seq.start ? RUN : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign seq.busy     = run;
  assign seq.done     = state_q == DONE;
  assign seq.round    = run ? round_q : 4'd0;
  assign seq.phase    = run ? phase_q : 2'd0;
  assign seq.init_sel = run && round_q == 4'd0;
  assign seq.step_en  = run && last_ph;
  assign seq.mix_en   = run && round_q != 4'd0 && !last_rnd;
  // rc holds 01 through round 0 and first advances on the wrap out of round 1
  aes_rcon_gen u_rcon (
    .clk     (clk),
    .reset   (reset),
    .load    (!run || seq.abort),
    .advance (run && last_ph && round_q != 4'd0 && !last_rnd),
    .valid   (run && round_q != 4'd0),
    .rcon    (seq.rcon)
  );
endmodule

// File: tb/tb_aes_round_seq.sv
// tb_aes_round_seq: scoreboard bench running NK=4/CPR=1 and NK=8/CPR=2 sequencers in lockstep
module tb_aes_round_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  always #5 clk = ~clk;
  aes_round_seq_if seq0();
  aes_round_seq_if seq1();
  assign seq0.start = start;
  assign seq0.abort = abort;
  assign seq1.start = start;
  assign seq1.abort = abort;
  aes_round_seq #(.NK(4), .CPR(1)) dut0 (.clk(clk), .reset(reset), .seq(seq0));
  aes_round_seq #(.NK(8), .CPR(2)) dut1 (.clk(clk), .reset(reset), .seq(seq1));
  int checks = 0;
  int errors = 0;
  logic [42:0] q0[$];
  logic [42:0] q1[$];
  logic [42:0] g0, g1;
  int m_st[2] = '{0, 0};
  int m_r[2] = '{0, 0};
  int m_p[2] = '{0, 0};
  int nrs[2] = '{10, 14};
  int cprs[2] = '{1, 2};
  logic [7:0] rct[14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                          8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};
  int step_cnt[2];
  int init_cnt[2];
  logic [31:0] rcon14 = 32'h0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [42:0] model_out(input int i);
    logic run;
    logic [31:0] rc;
    run = m_st[i] == 1;
    rc = (run && m_r[i] >= 1) ? {rct[m_r[i] - 1], 24'h0} : 32'h0;
    return {run, m_st[i] == 2, 4'(m_r[i]), 2'(m_p[i]), run && m_r[i] == 0,
            run && m_p[i] == cprs[i] - 1, run && m_r[i] >= 1 && m_r[i] < nrs[i], rc};
  endfunction
  task automatic model_step(input int i);
    if (reset) begin
      m_st[i] = 0; m_r[i] = 0; m_p[i] = 0;
    end else if (m_st[i] == 0) begin
      if (start && !abort) m_st[i] = 1;
    end else if (m_st[i] == 1) begin
      if (abort) begin
        m_st[i] = 0; m_r[i] = 0; m_p[i] = 0;
      end else if (m_p[i] == cprs[i] - 1) begin
        m_p[i] = 0;
        if (m_r[i] == nrs[i]) begin
          m_st[i] = 2; m_r[i] = 0;
        end else m_r[i]++;
      end else m_p[i]++;
    end else begin
      if (abort) m_st[i] = 0;
      else if (start) m_st[i] = 1;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
    @(negedge clk);
    g0 = {seq0.busy, seq0.done, seq0.round, seq0.phase, seq0.init_sel, seq0.step_en, seq0.mix_en, seq0.rcon};
    g1 = {seq1.busy, seq1.done, seq1.round, seq1.phase, seq1.init_sel, seq1.step_en, seq1.mix_en, seq1.rcon};
    check("nk4_outs", 64'(g0), 64'(q0.pop_front()));
    check("nk8_outs", 64'(g1), 64'(q1.pop_front()));
    if (seq0.step_en) step_cnt[0]++;
    if (seq1.step_en) step_cnt[1]++;
    if (seq0.init_sel) init_cnt[0]++;
    if (seq1.init_sel) init_cnt[1]++;
    if (seq1.round == 4'd14) rcon14 = seq1.rcon;
  endtask
  task automatic measure(input bit pulse, output int l0, output int l1, output logic [5:0] first0);
    l0 = -1;
    l1 = -1;
    first0 = 6'h3F;
    step_cnt = '{0, 0};
    init_cnt = '{0, 0};
    start = 1'b1;
    for (int k = 1; k <= 40 && (l0 < 0 || l1 < 0); k++) begin
      tick();
      if (k == 1) first0 = {seq0.busy, seq0.done, seq0.round};
      start = pulse && k < 10 && (k % 2 == 1);
      if (l0 < 0 && seq0.done) l0 = k;
      if (l1 < 0 && seq1.done) l1 = k;
    end
    start = 1'b0;
  endtask
  task automatic wait_round0(input logic [3:0] r, output bit found);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (seq0.round == r) found = 1'b1;
      else tick();
    end
  endtask
  initial begin
    int l0, l1;
    logic [5:0] f0;
    bit found;
    repeat (3) tick();
    check("rst_nk4", 64'(g0), 64'h0);
    check("rst_nk8", 64'(g1), 64'h0);
    reset = 1'b0;
    tick();
    measure(1'b0, l0, l1, f0);
    check("lat_nk4", l0, 12);
    check("lat_nk8", l1, 31);
    check("steps_nk4", step_cnt[0], 11);
    check("steps_nk8", step_cnt[1], 15);
    check("init_nk4", init_cnt[0], 1);
    check("init_nk8", init_cnt[1], 2);
    check("rcon_r14", rcon14, 32'h4D000000);
    repeat (20) tick();
    check("done_held4", seq0.done, 1);
    check("done_held8", seq1.done, 1);
    measure(1'b0, l0, l1, f0);
    check("b2b_first", f0, 6'b100000);
    check("b2b_lat4", l0, 12);
    check("b2b_lat8", l1, 31);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_round0(4'd5, found);
    check("reach_r5", found, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", seq0.busy, 0);
    check("abort_rcon", seq0.rcon, 32'h0);
    step_cnt = '{0, 0};
    repeat (5) tick();
    check("abort_steps4", step_cnt[0], 0);
    check("abort_steps8", step_cnt[1], 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_round", seq0.round, 0);
    check("restart_init", seq0.init_sel, 1);
    tick();
    check("restart_rcon", seq0.rcon, 32'h01000000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_idle4", seq0.busy, 0);
    check("sa_idle8", seq1.busy, 0);
    measure(1'b1, l0, l1, f0);
    check("pulse_lat4", l0, 12);
    check("pulse_lat8", l1, 31);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_round0(4'd3, found);
    check("reach_r3", found, 1);
    reset = 1'b1;
    start = 1'b1;
    tick();
    check("rstrun_nk4", 64'(g0), 64'h0);
    check("rstrun_nk8", 64'(g1), 64'h0);
    reset = 1'b0;
    start = 1'b0;
    step_cnt = '{0, 0};
    repeat (5) tick();
    check("rstrun_steps4", step_cnt[0], 0);
    check("rstrun_steps8", step_cnt[1], 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
